// File: rtl/key_rd_pkg.sv
// Shared types and defaults for the key-word table reader.
// Optional second verify pass is enabled by KEY_READ_VERIFY_EN.
package key_rd_pkg;

  localparam int KEY_WORD_W     = 16;
  localparam int KEY_NUM_WORDS  = 4;
  localparam int KEY_RD_LATENCY = 3;
  localparam int KEY_IDX_W      = $clog2(KEY_NUM_WORDS);

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    VERIFY,
    FIN
  } key_rd_state_e;

endpackage

// File: rtl/key_rd_tag_pipe.sv
// Valid+index delay line that tracks each issued address
// until its word emerges from the table pipeline.
module key_rd_tag_pipe
  import key_rd_pkg::*;
#(
  parameter int DEPTH = KEY_RD_LATENCY,
  parameter int IDX_W = KEY_IDX_W
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_vld,
  output logic [IDX_W-1:0] o_idx
);

  logic [DEPTH-1:0] r_vld;
  logic [IDX_W-1:0] r_idx [DEPTH];

  // shift tags one stage per cycle; reset drops in-flight tags
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_vld[i] <= 1'b0;
        r_idx[i] <= '0;
      end
    end else begin
      r_vld[0] <= i_vld;
      r_idx[0] <= i_idx;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_idx[i] <= r_idx[i-1];
      end
    end
  end

  assign o_vld = r_vld[DEPTH-1];
  assign o_idx = r_idx[DEPTH-1];

endmodule

// File: rtl/key_word_reader.sv
// Fetches the locking key word by word from the pipelined key table.
// Define KEY_READ_VERIFY_EN for a second read-back pass driving mismatch.
module key_word_reader
  import key_rd_pkg::*;
#(
  parameter int WORD_W     = KEY_WORD_W,
  parameter int NUM_WORDS  = KEY_NUM_WORDS,
  parameter int ADDR_W     = 2,
  parameter int RD_LATENCY = KEY_RD_LATENCY
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic [ADDR_W-1:0]           rd_addr,
  input  logic [WORD_W-1:0]           rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        key_valid,
  output logic [NUM_WORDS*WORD_W-1:0] key_o,
  output logic                        mismatch
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_WORDS - 1);

  key_rd_state_e r_state;
  key_rd_state_e w_next;

  logic [ADDR_W-1:0]           r_addr;
  logic [NUM_WORDS*WORD_W-1:0] r_key;
  logic                        r_key_valid;
  logic [NUM_WORDS*WORD_W-1:0] w_new_key;
  logic                        w_issue;
  logic                        w_tag_vld;
  logic [ADDR_W-1:0]           w_tag_idx;
  logic                        w_last_cap;
  logic                        w_busy;
  logic                        w_done;

`ifdef KEY_READ_VERIFY_EN
  logic              r_vpass;
  logic              r_acc;
  logic              r_mis;
  logic [WORD_W-1:0] w_cur_word;
  logic              w_acc_next;
`endif

  assign w_issue    = (r_state == ISSUE) ||
                      (r_state == VERIFY);
  assign w_last_cap = w_tag_vld && (w_tag_idx == LAST);

  key_rd_tag_pipe #(
    .DEPTH (RD_LATENCY),
    .IDX_W (ADDR_W)
  ) u_tag (
    .i_clk (clk),
    .i_rst (rst),
    .i_vld (w_issue),
    .i_idx (r_addr),
    .o_vld (w_tag_vld),
    .o_idx (w_tag_idx)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // next-state: issue, drain, optional verify pass, finish
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:   if (start) w_next = ISSUE;
      ISSUE:  if (r_addr == LAST) w_next = DRAIN;
      DRAIN: begin
        if (w_last_cap) begin
`ifdef KEY_READ_VERIFY_EN
          w_next = r_vpass ? FIN : VERIFY;
`else
          w_next = FIN;
`endif
        end
      end
      VERIFY: if (r_addr == LAST) w_next = DRAIN;
      FIN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    w_busy = (r_state != IDLE);
    w_done = (r_state == FIN);
  end

  // returned word merged into its slot of the key
  always_comb begin
    w_new_key = r_key;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (w_tag_idx == ADDR_W'(i))
        w_new_key[i*WORD_W +: WORD_W] = rd_data;
    end
  end

`ifdef KEY_READ_VERIFY_EN
  // stored word for the returning tag, compared on the verify pass
  always_comb begin
    w_cur_word = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (w_tag_idx == ADDR_W'(i))
        w_cur_word = r_key[i*WORD_W +: WORD_W];
    end
    w_acc_next = r_acc |
      (w_tag_vld && r_vpass && (w_cur_word != rd_data));
  end
`endif

  // address counter, key capture and result flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_key       <= '0;
      r_key_valid <= 1'b0;
`ifdef KEY_READ_VERIFY_EN
      r_vpass     <= 1'b0;
      r_acc       <= 1'b0;
      r_mis       <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && start) begin
        r_addr      <= '0;
        r_key_valid <= 1'b0;
`ifdef KEY_READ_VERIFY_EN
        r_vpass     <= 1'b0;
        r_acc       <= 1'b0;
        r_mis       <= 1'b0;
`endif
      end else if (w_issue && r_addr != LAST) begin
        r_addr <= r_addr + ADDR_W'(1);
      end
`ifdef KEY_READ_VERIFY_EN
      if (r_state == DRAIN && w_next == VERIFY) begin
        r_addr  <= '0;
        r_vpass <= 1'b1;
      end
      if (w_tag_vld) begin
        if (r_vpass) r_acc <= w_acc_next;
        else         r_key <= w_new_key;
      end
`else
      if (w_tag_vld) r_key <= w_new_key;
`endif
      if (r_state != FIN && w_next == FIN) begin
        r_key_valid <= 1'b1;
`ifdef KEY_READ_VERIFY_EN
        r_mis       <= w_acc_next;
`endif
      end
    end
  end

  assign rd_addr   = r_addr;
  assign key_o     = r_key;
  assign key_valid = r_key_valid;
  assign busy      = w_busy;
  assign done      = w_done;
`ifdef KEY_READ_VERIFY_EN
  assign mismatch  = r_mis;
`else
  assign mismatch  = 1'b0;
`endif

endmodule
